// File: rtl/score_bcd_keeper_pkg.sv
// Shared types and constants for the BCD score keeper and its converter.
package score_pkg;
    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {IDLE, CONV, ADD, COMMIT} state_t;
endpackage

// File: rtl/score_bcd_keeper_bin2bcd.sv
// Iterative double-dabble converter: one shift/adjust step per clock, POINT_W steps per award.
module bin2bcd_serial
    import score_pkg::*;
#(
    parameter int POINT_W   = 8,
    parameter int PT_DIGITS = 3
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iAbort,
    input  logic                         iStart,
    input  logic [POINT_W-1:0]           iBin,
    output logic                         oDone,
    output logic [BCD_W*PT_DIGITS-1:0]   oBcd
);
    localparam int ACC_W = BCD_W * PT_DIGITS;
    localparam int CNT_W = $clog2(POINT_W + 1);

    logic [POINT_W-1:0] r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [ACC_W-1:0]   w_adj;

    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < PT_DIGITS; d++) begin
            if (w_adj[BCD_W*d +: BCD_W] >= 4'd5)
                w_adj[BCD_W*d +: BCD_W] = w_adj[BCD_W*d +: BCD_W] + 4'd3;
        end
    end

    // oDone marks the edge that performs the final step, so the result is registered right after it.
    assign oDone = r_busy && (r_cnt == CNT_W'(POINT_W - 1));
    assign oBcd  = r_acc;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_bin  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (iAbort) begin
            r_busy <= 1'b0;
        end else if (iStart) begin
            r_bin  <= iBin;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= {w_adj[ACC_W-2:0], r_bin[POINT_W-1]};
            r_bin <= {r_bin[POINT_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (oDone)
                r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/score_bcd_keeper.sv
// Player/high score keeper in packed BCD: serial award conversion, digit-serial add, saturation, show flags.
module score_bcd_keeper
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int POINT_W    = 8,
    parameter int PT_DIGITS  = 3
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic                        iAddValid,
    input  logic [POINT_W-1:0]          iAddPoints,
    output logic                        oAddReady,
    input  logic                        iClear,
    input  logic                        iGameOver,
    output logic [BCD_W*NUM_DIGITS-1:0] oScoreDigits,
    output logic [NUM_DIGITS-1:0]       oScoreShow,
    output logic [BCD_W*NUM_DIGITS-1:0] oHiDigits,
    output logic [NUM_DIGITS-1:0]       oHiShow,
    output logic                        oSaturated
);
    localparam int SC_W  = BCD_W * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [SC_W-1:0] ALL_NINES = {NUM_DIGITS{BCD_NINE}};

    state_t                       r_state, w_next;
    logic [SC_W-1:0]              r_score, r_shadow, r_hi;
    logic                         r_sat, r_carry;
    logic [IDX_W-1:0]             r_idx;
    logic                         w_accept, w_conv_done, w_last_digit, w_cout;
    logic [BCD_W*PT_DIGITS-1:0]   w_conv_bcd;
    logic [SC_W-1:0]              w_addend, w_commit_score, w_hi_cand;
    logic [BCD_W-1:0]             w_a, w_b, w_digit;
    logic [BCD_W:0]               w_sum;

    bin2bcd_serial #(.POINT_W(POINT_W), .PT_DIGITS(PT_DIGITS)) u_conv (
        .iClk   (iClk),
        .iReset (iReset),
        .iAbort (iClear),
        .iStart (w_accept),
        .iBin   (iAddPoints),
        .oDone  (w_conv_done),
        .oBcd   (w_conv_bcd)
    );

    assign w_accept     = iAddValid && (r_state == IDLE) && !iClear;
    assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_addend     = SC_W'(w_conv_bcd);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (iAddValid)    w_next = CONV;
            CONV:    if (w_conv_done)  w_next = ADD;
            ADD:     if (w_last_digit) w_next = COMMIT;
            COMMIT:                    w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
        if (iClear) w_next = IDLE;
    end

    always_comb begin
        oAddReady = (r_state == IDLE);
    end

    // Digit-serial BCD add: select the current digit of score and addend, correct sums above nine.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a = r_score[BCD_W*i +: BCD_W];
                w_b = w_addend[BCD_W*i +: BCD_W];
            end
        end
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {{BCD_W{1'b0}}, r_carry};
        if (w_sum > 5'd9) begin
            w_digit = BCD_W'(w_sum - 5'd10);
            w_cout  = 1'b1;
        end else begin
            w_digit = w_sum[BCD_W-1:0];
            w_cout  = 1'b0;
        end
    end

    assign w_commit_score = r_carry ? ALL_NINES : r_shadow;
    // A game-over landing on a commit must see the committed score; a clear never hides the old score.
    assign w_hi_cand = ((r_state == COMMIT) && !iClear) ? w_commit_score : r_score;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_shadow <= '0;
        end else if (r_state == CONV && w_conv_done) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
        end else if (r_state == ADD) begin
            r_idx   <= r_idx + 1'b1;
            r_carry <= w_cout;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_idx == IDX_W'(i))
                    r_shadow[BCD_W*i +: BCD_W] <= w_digit;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_score <= '0;
            r_sat   <= 1'b0;
        end else if (iClear) begin
            r_score <= '0;
            r_sat   <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_score <= w_commit_score;
            if (r_carry) r_sat <= 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)
            r_hi <= '0;
        else if (iGameOver && (w_hi_cand > r_hi))
            r_hi <= w_hi_cand;
    end

    // show[i] is set when any digit at or above position i is nonzero; the ones digit is always shown.
    always_comb begin
        logic w_any_s, w_any_h;
        w_any_s = 1'b0;
        w_any_h = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_any_s       = w_any_s | (r_score[BCD_W*i +: BCD_W] != '0);
            w_any_h       = w_any_h | (r_hi[BCD_W*i +: BCD_W] != '0);
            oScoreShow[i] = w_any_s;
            oHiShow[i]    = w_any_h;
        end
        oScoreShow[0] = 1'b1;
        oHiShow[0]    = 1'b1;
    end

    assign oScoreDigits = r_score;
    assign oHiDigits    = r_hi;
    assign oSaturated   = r_sat;
endmodule

// File: tb/tb_score_bcd_keeper.sv
// Directed bench for score_bcd_keeper with a decimal reference model and expected-score queue.
module tb_score_bcd_keeper;
    logic        iClk, iReset, iAddValid, iClear, iGameOver;
    logic [7:0]  iAddPoints;
    logic        oAddReady, oSaturated;
    logic [19:0] oScoreDigits, oHiDigits;
    logic [4:0]  oScoreShow, oHiShow;

    int n_checks = 0;
    int n_errors = 0;
    int model_score = 0;
    int model_hi = 0;
    bit model_sat = 0;
    logic [19:0] exp_q[$];

    score_bcd_keeper dut (
        .iClk(iClk), .iReset(iReset), .iAddValid(iAddValid), .iAddPoints(iAddPoints),
        .oAddReady(oAddReady), .iClear(iClear), .iGameOver(iGameOver),
        .oScoreDigits(oScoreDigits), .oScoreShow(oScoreShow), .oHiDigits(oHiDigits),
        .oHiShow(oHiShow), .oSaturated(oSaturated)
    );

    initial begin
        iClk = 0;
        forever #5 iClk = ~iClk;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int div;
        r = '0;
        div = 1;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] to_show(input int v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return 5'((1 << n) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !oAddReady; i++) begin
            @(posedge iClk); #1;
        end
        if (!oAddReady) check("ready_timeout", 32'(oAddReady), 32'd1);
    endtask

    // Caller is #1 after an edge. Verbose mode also checks busy/latency behaviour.
    task automatic do_award(input int p, input bit verbose);
        int old;
        logic [19:0] exp_v;
        wait_ready();
        old = model_score;
        if (model_score + p > 99999) begin
            model_score = 99999;
            model_sat   = 1;
        end else begin
            model_score = model_score + p;
        end
        exp_q.push_back(to_bcd(model_score));
        iAddValid  = 1;
        iAddPoints = 8'(p);
        @(posedge iClk); #1;
        iAddValid = 0;
        if (verbose) check("busy_after_accept", 32'(oAddReady), 32'd0);
        repeat (13) @(posedge iClk);
        #1;
        if (verbose) check("score_before_commit", 32'(oScoreDigits), 32'(to_bcd(old)));
        @(posedge iClk); #1;
        exp_v = exp_q.pop_front();
        check("score_after_commit", 32'(oScoreDigits), 32'(exp_v));
        if (verbose) begin
            check("ready_after_commit", 32'(oAddReady), 32'd1);
            check("score_show", 32'(oScoreShow), 32'(to_show(model_score)));
            check("saturated", 32'(oSaturated), 32'(model_sat));
        end
    endtask

    task automatic pulse_clear();
        iClear = 1;
        @(posedge iClk); #1;
        iClear = 0;
        model_score = 0;
        model_sat   = 0;
    endtask

    task automatic pulse_gameover();
        iGameOver = 1;
        @(posedge iClk); #1;
        iGameOver = 0;
        if (model_score > model_hi) model_hi = model_score;
    endtask

    initial begin
        logic [19:0] exp_v;
        iReset = 1; iAddValid = 0; iAddPoints = '0; iClear = 0; iGameOver = 0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_score", 32'(oScoreDigits), 32'd0);
        check("rst_hi", 32'(oHiDigits), 32'd0);
        check("rst_sat", 32'(oSaturated), 32'd0);
        check("rst_ready", 32'(oAddReady), 32'd1);
        check("rst_show", 32'(oScoreShow), 32'b00001);
        check("rst_hishow", 32'(oHiShow), 32'b00001);
        iReset = 0;
        @(posedge iClk); #1;

        do_award(25, 1);
        check("show_25", 32'(oScoreShow), 32'b00011);

        pulse_clear();
        do_award(255, 0); do_award(255, 0); do_award(255, 0); do_award(234, 0);
        do_award(1, 1);
        check("show_1000", 32'(oScoreShow), 32'b01111);

        pulse_clear();
        do_award(255, 0);
        do_award(255, 1);

        do_award(0, 1);

        pulse_clear();
        for (int i = 0; i < 392; i++) do_award(255, 0);
        do_award(30, 1);
        do_award(15, 1);
        check("sat_value", 32'(oScoreDigits), 32'h99999);
        do_award(200, 1);

        // Held request: second value is only taken when the block is idle again.
        pulse_clear();
        wait_ready();
        exp_q.push_back(to_bcd(100));
        iAddValid = 1; iAddPoints = 8'd100;
        @(posedge iClk); #1;
        iAddPoints = 8'd7;
        check("held_busy", 32'(oAddReady), 32'd0);
        repeat (13) @(posedge iClk);
        #1;
        check("held_no_early", 32'(oScoreDigits), 32'd0);
        @(posedge iClk); #1;
        exp_v = exp_q.pop_front();
        check("held_first", 32'(oScoreDigits), 32'(exp_v));
        check("held_ready", 32'(oAddReady), 32'd1);
        exp_q.push_back(to_bcd(107));
        @(posedge iClk); #1;
        iAddValid = 0;
        check("held_second_accepted", 32'(oAddReady), 32'd0);
        repeat (14) @(posedge iClk);
        #1;
        exp_v = exp_q.pop_front();
        check("held_final", 32'(oScoreDigits), 32'(exp_v));
        model_score = 107;

        // Clear during conversion aborts the award.
        pulse_clear();
        do_award(5, 0);
        wait_ready();
        iAddValid = 1; iAddPoints = 8'd50;
        @(posedge iClk); #1;
        iAddValid = 0;
        repeat (2) @(posedge iClk);
        #1;
        iClear = 1;
        @(posedge iClk); #1;
        iClear = 0;
        model_score = 0;
        check("abort_score", 32'(oScoreDigits), 32'd0);
        check("abort_idle", 32'(oAddReady), 32'd1);
        repeat (20) @(posedge iClk);
        #1;
        check("abort_no_commit", 32'(oScoreDigits), 32'd0);

        // Award offered with clear is dropped.
        iClear = 1; iAddValid = 1; iAddPoints = 8'd9;
        @(posedge iClk); #1;
        iClear = 0; iAddValid = 0;
        check("clear_blocks_accept", 32'(oAddReady), 32'd1);
        repeat (16) @(posedge iClk);
        #1;
        check("clear_blocks_score", 32'(oScoreDigits), 32'd0);

        // High score.
        do_award(250, 0); do_award(250, 0);
        pulse_gameover();
        check("hi_500", 32'(oHiDigits), 32'(to_bcd(model_hi)));
        pulse_clear();
        for (int i = 0; i < 4; i++) do_award(255, 0);
        do_award(214, 0);
        pulse_gameover();
        check("hi_1234", 32'(oHiDigits), 32'h01234);
        check("hishow_1234", 32'(oHiShow), 32'b01111);
        pulse_clear();
        pulse_gameover();
        check("hi_kept", 32'(oHiDigits), 32'h01234);

        for (int i = 0; i < 7; i++) do_award(255, 0);
        do_award(215, 0);
        iClear = 1; iGameOver = 1;
        @(posedge iClk); #1;
        iClear = 0; iGameOver = 0;
        if (model_score > model_hi) model_hi = model_score;
        model_score = 0;
        check("hi_pre_clear", 32'(oHiDigits), 32'(to_bcd(model_hi)));
        check("score_cleared", 32'(oScoreDigits), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
